// File: rtl/bridge_arb_pkg.sv
// Shared types and default parameters for the bridge arbiter.
package bridge_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } arb_state_e;

    localparam int unsigned DefNumCh      = 4;
    localparam int unsigned DefAddrW      = 26;
    localparam int unsigned DefDataW      = 16;
    localparam int unsigned DefTimeoutCyc = 1024;

    // Byte-enable width for a byte-multiple data bus.
    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first requester at or after the
// pointer (wrapping) receives a one-hot grant.
module rr_arbiter #(
    parameter int unsigned NumCh = 4,
    localparam int unsigned PtrW = $clog2(NumCh)
) (
    input  logic [NumCh-1:0] req_i,
    input  logic [PtrW-1:0]  ptr_i,
    output logic [NumCh-1:0] grant_o
);

    // Walk offsets 0..NumCh-1 from the pointer; first requester wins.
    always_comb begin
        logic        found;
        int unsigned idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < NumCh; off++) begin
            idx = (32'(ptr_i) + off) % NumCh;
            for (int unsigned i = 0; i < NumCh; i++) begin
                if (!found && (i == idx) && req_i[i]) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Multi-channel arbiter in front of a single bridge master port.
// Round-robin picks one requesting channel, its fields are latched and
// presented on the bridge until acknowledge, then a one-cycle ch_done pulse
// reports completion to the granted channel.
// Optional feature: define BRIDGE_ARB_TIMEOUT_EN to add an acknowledge
// watchdog that aborts after TIMEOUT_CYC cycles and flags ch_err.
module bridge_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int unsigned NUM_CH      = DefNumCh,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    localparam int unsigned BE_W       = be_width(DATA_W)
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*BE_W-1:0]   ch_be,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [ADDR_W-1:0]        bridge_address,
    output logic [BE_W-1:0]          bridge_byte_enable,
    output logic                     bridge_read,
    output logic                     bridge_write,
    output logic [DATA_W-1:0]        bridge_write_data,
    input  logic                     bridge_acknowledge,
    input  logic [DATA_W-1:0]        bridge_read_data
);

    localparam int unsigned PTR_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("NUM_CH must be within 2..8");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("DATA_W must be a non-zero multiple of 8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]   done_q, done_d;

    logic [NUM_CH-1:0]   grant;
    logic [PTR_W-1:0]    sel_idx;
    logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
    logic [BE_W-1:0]     be_arr    [NUM_CH];
    logic [DATA_W-1:0]   wdata_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unflatten
        assign addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
        assign be_arr[g]    = ch_be[g*BE_W +: BE_W];
        assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NumCh (NUM_CH)
    ) u_rr_arbiter (
        .req_i   (ch_req),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // One-hot grant to channel index.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_idx = PTR_W'(i);
            end
        end
    end

`ifdef BRIDGE_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [NUM_CH-1:0] err_q, err_d;
`endif

    // Next-state logic: arbitrate, hold the strobe until ack, then report.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        done_d  = '0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = '0;
`endif
        case (state_q)
            StIdle: begin
                if (|ch_req) begin
                    gnt_d   = sel_idx;
                    addr_d  = addr_arr[sel_idx];
                    be_d    = be_arr[sel_idx];
                    wdata_d = wdata_arr[sel_idx];
                    wr_d    = ch_we[sel_idx];
                    rd_d    = ~ch_we[sel_idx];
                    // Next search starts just past the channel served now.
                    ptr_d   = (sel_idx == PTR_W'(NUM_CH - 1)) ? '0 : sel_idx + 1'b1;
                    state_d = StIssue;
`ifdef BRIDGE_ARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            StIssue: begin
                if (bridge_acknowledge) begin
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    rdata_d       = wr_q ? '0 : bridge_read_data;
                    done_d[gnt_q] = 1'b1;
                    state_d       = StDone;
                end
`ifdef BRIDGE_ARB_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    rdata_d       = '0;
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                    state_d       = StDone;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= '0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bridge_address     = addr_q;
    assign bridge_byte_enable = be_q;
    assign bridge_write_data  = wdata_q;
    assign bridge_read        = rd_q;
    assign bridge_write       = wr_q;
    assign ch_done            = done_q;
    assign ch_rdata           = rdata_q;
`ifdef BRIDGE_ARB_TIMEOUT_EN
    assign ch_err             = err_q;
`else
    assign ch_err             = '0;
`endif

endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of client channels, range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 26: bridge address width.
REQ-003 SHALL have parameter DATA_W, default 16: data width, multiple of 8; BE_W = DATA_W/8.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: acknowledge watchdog limit in cycles.
REQ-005 SHALL have port clk_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port ch_req, input, NUM_CH bits: per-channel request level.
REQ-008 SHALL have port ch_we, input, NUM_CH bits: per-channel 1=write, 0=read.
REQ-009 SHALL have port ch_addr, input, NUM_CH*ADDR_W bits: flattened addresses, channel i at [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port ch_be, input, NUM_CH*BE_W bits: flattened byte enables.
REQ-011 SHALL have port ch_wdata, input, NUM_CH*DATA_W bits: flattened write data.
REQ-012 SHALL have port ch_done, output, NUM_CH bits: one-cycle completion pulse per channel.
REQ-013 SHALL have port ch_err, output, NUM_CH bits: timeout flag, valid with ch_done.
REQ-014 SHALL have port ch_rdata, output, DATA_W bits: shared read data, valid with ch_done.
REQ-015 SHALL have ports bridge_address (output, ADDR_W), bridge_byte_enable (output, BE_W), bridge_read (output, 1), bridge_write (output, 1) and bridge_write_data (output, DATA_W).
REQ-016 SHALL have ports bridge_acknowledge (input, 1) and bridge_read_data (input, DATA_W).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-018 IDLE: if any ch_req is high, SHALL select a channel by round-robin, latch its we/addr/be/wdata, and go to ISSUE on the next edge; otherwise SHALL stay in IDLE.
REQ-019 Round-robin: after serving channel k, search SHALL start at k+1 mod NUM_CH; the pointer after reset SHALL be 0.
REQ-020 ISSUE: SHALL hold exactly one of bridge_read/bridge_write high with latched fields stable until bridge_acknowledge is sampled high.
REQ-021 On ack, SHALL register bridge_read_data into ch_rdata (write: ch_rdata SHALL be 0), drop the strobe on the next edge, and enter DONE.
REQ-022 DONE: SHALL pulse ch_done[granted] for exactly one cycle, then return to IDLE.
REQ-023 Latency: request seen at IDLE edge N SHALL give strobe high at N+1; ack at edge M SHALL give ch_done at M+1; minimum turnaround is 3 cycles per transaction.
REQ-024 Clients SHALL hold request fields until ch_done; a request dropped mid-transaction SHALL NOT abort it, and completion SHALL still pulse.
REQ-025 A client keeping ch_req high after ch_done SHALL be rearbitrated as a new request.
REQ-026 bridge_acknowledge outside ISSUE SHALL be ignored.
REQ-027 A channel with both ch_we and ch_req high SHALL issue a write; byte enables SHALL pass unmodified, including all-zero.

Reset
REQ-028 When reset_reset_n is low at an edge: state SHALL be IDLE, all bridge_* outputs 0, ch_done 0, ch_err 0, ch_rdata 0, RR pointer 0, watchdog 0.
REQ-029 Reset during ISSUE SHALL drop the strobe at that edge with no ch_done for the aborted transaction.

Configuration
REQ-030 With BRIDGE_ARB_TIMEOUT_EN defined: a counter SHALL run in ISSUE; if it reaches TIMEOUT_CYC-1 without ack, the strobe SHALL drop, DONE SHALL be entered, ch_err[granted] SHALL be 1 with ch_done, and ch_rdata SHALL be 0.
REQ-031 Without BRIDGE_ARB_TIMEOUT_EN: ISSUE SHALL wait indefinitely, ch_err SHALL be constant 0, and no counter SHALL be synthesised.

Structure
REQ-032 Package bridge_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Round-robin selection SHALL be sub-module rr_arbiter (NUM_CH request, pointer in, one-hot grant out), combinational.

Verification
REQ-034 Single read ch1, addr 0x0000100, ack after 2 cycles with 0xBEEF -> bridge_read held 3 cycles, ch_done[1] pulse, ch_rdata 0xBEEF, ch_err 0.
REQ-035 All 4 channels request continuously, immediate ack -> grant order 0,1,2,3,0 with no skips.
REQ-036 Write ch2, be 2'b01, data 0x1234 -> bridge_write with be 01, data 0x1234; ch_done[2] one cycle after ack.
REQ-037 Macro defined, TIMEOUT_CYC=16, no ack -> strobe drops after 16 cycles, ch_done[0] with ch_err[0]=1; macro undefined -> strobe stays high indefinitely.
REQ-038 Reset asserted mid-ISSUE -> next edge all outputs 0, no ch_done; after release, pending ch3 is granted first from pointer 0 only if ch0..ch2 are idle.
